// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer.
// Forward selects, PC register id and the multicycle FSM state.
package hazard_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } mc_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] REG_PC = 4'hF;

  // M beats W; the PC register is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       wr_m,
    input logic [3:0] wa_m,
    input logic       wr_w,
    input logic [3:0] wa_w
  );
    fwd_sel = FWD_RF;
    if (src != REG_PC) begin
      if (wr_m && (wa_m == src)) begin
        fwd_sel = FWD_M;
      end else if (wr_w && (wa_w == src)) begin
        fwd_sel = FWD_W;
      end
    end
  endfunction

endpackage

// File: rtl/mc_handshake_fsm.sv
// Multicycle execute handshake: start pulse, busy hold,
// timeout release and the sticky timeout error flag.
import hazard_pkg::*;

module mc_handshake_fsm #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic taken,
  input  logic done,
  output logic go,
  output logic hold,
  output logic err
);

  localparam int CW =
    (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MC_TIMEOUT - 1);

  mc_state_t       state;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic            tmo;
  logic            release_now;

  assign busy = (state == BUSY);
  assign tmo  = busy && (cnt == CNT_MAX) && !done;
  assign release_now = busy && (done || tmo);

  // A taken branch squashes the starting instruction.
  assign go = (state == IDLE) && start
              && !taken && !reset;

  // Hold the front end from the start cycle until release.
  assign hold = go || (busy && !release_now);

  // State, timeout counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= BUSY;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state <= IDLE;
            if (tmo) begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard unit: forwarding, load-use stalls, PC flushes
// and multicycle hold. Optional perf counters: HAZARD_PERF_EN.
import hazard_pkg::*;

module hazard_sequencer #(
  parameter int MC_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Ra1D,
  input  logic [3:0] Ra2D,
  input  logic [3:0] Ra1E,
  input  logic [3:0] Ra2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  input  logic       MulDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulGo,
  output logic       MulErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] StallCount,
  output logic [PERF_W-1:0] FlushCount
`endif
);

  logic ld_stall;
  logic pc_pend;
  logic hold;

  mc_handshake_fsm #(
    .MC_TIMEOUT(MC_TIMEOUT)
  ) u_mc (
    .clk  (clk),
    .reset(reset),
    .start(MulStartE),
    .taken(BranchTakenE),
    .done (MulDone),
    .go   (MulGo),
    .hold (hold),
    .err  (MulErr)
  );

  assign ld_stall = MemtoRegE &&
    ((WA3E == Ra1D) || (WA3E == Ra2D));
  assign pc_pend = PCSrcD || PCSrcE || PCSrcM;

  // Forward selects for both execute operands.
  always_comb begin
    ForwardAE = fwd_sel(Ra1E, RegWriteM, WA3M,
                        RegWriteW, WA3W);
    ForwardBE = fwd_sel(Ra2E, RegWriteM, WA3M,
                        RegWriteW, WA3W);
  end

  // Multicycle hold overrides the normal stall/flush terms.
  always_comb begin
    StallF = ld_stall || pc_pend;
    StallD = ld_stall;
    StallE = 1'b0;
    FlushD = pc_pend || PCSrcW || BranchTakenE;
    FlushE = ld_stall || BranchTakenE;
    FlushM = 1'b0;
    if (hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && !(&StallCount)) begin
        StallCount <= StallCount + 1'b1;
      end
      if (FlushE && !(&FlushCount)) begin
        FlushCount <= FlushCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed cases
// then randomized cycles against a cycle-level reference model.
module tb_hazard_sequencer;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic       BranchTakenE, MulStartE, MulDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       MulGo, MulErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_busy = 0;
  int m_elapsed = 0;
  bit m_err = 0;
  longint m_sc = 0;
  longint m_fc = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(
    .MC_TIMEOUT(TMO)
`ifdef HAZARD_PERF_EN
    ,
    .PERF_W(32)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Ra1D        (Ra1D),
    .Ra2D        (Ra2D),
    .Ra1E        (Ra1E),
    .Ra2E        (Ra2E),
    .WA3E        (WA3E),
    .WA3M        (WA3M),
    .WA3W        (WA3W),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .PCSrcD      (PCSrcD),
    .PCSrcE      (PCSrcE),
    .PCSrcM      (PCSrcM),
    .PCSrcW      (PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MulStartE   (MulStartE),
    .MulDone     (MulDone),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .MulGo       (MulGo),
    .MulErr      (MulErr)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount  (StallCount),
    .FlushCount  (FlushCount)
`endif
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(logic [3:0] src);
    if (src == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == src) return 2'b10;
    if (RegWriteW && WA3W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    reset = 0;
    Ra1D = 0; Ra2D = 0; Ra1E = 0; Ra2E = 0;
    WA3E = 1; WA3M = 2; WA3W = 3;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MulStartE = 0; MulDone = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance model.
  task automatic step();
    bit ld, pcp, go, rel, tmo_hit, hold;
    bit e_sf, e_sd, e_se, e_fd, e_fe, e_fm;
    if (reset) begin
      m_busy = 0; m_elapsed = 0; m_err = 0;
      m_sc = 0; m_fc = 0;
    end
    ld  = MemtoRegE && (WA3E == Ra1D || WA3E == Ra2D);
    pcp = PCSrcD || PCSrcE || PCSrcM;
    go  = !reset && !m_busy && MulStartE && !BranchTakenE;
    tmo_hit = m_busy && !MulDone && m_elapsed == TMO - 1;
    rel = m_busy && (MulDone || tmo_hit);
    hold = go || (m_busy && !rel);
    e_sf = hold || ld || pcp;
    e_sd = hold || ld;
    e_se = hold;
    e_fm = hold;
    e_fd = !hold && (pcp || PCSrcW || BranchTakenE);
    e_fe = !hold && (ld || BranchTakenE);
    #4;
    check("ForwardAE", 32'(ForwardAE), 32'(ref_fwd(Ra1E)));
    check("ForwardBE", 32'(ForwardBE), 32'(ref_fwd(Ra2E)));
    check("StallF", 32'(StallF), 32'(e_sf));
    check("StallD", 32'(StallD), 32'(e_sd));
    check("StallE", 32'(StallE), 32'(e_se));
    check("FlushD", 32'(FlushD), 32'(e_fd));
    check("FlushE", 32'(FlushE), 32'(e_fe));
    check("FlushM", 32'(FlushM), 32'(e_fm));
    check("MulGo", 32'(MulGo), 32'(go));
    check("MulErr", 32'(MulErr), 32'(m_err));
`ifdef HAZARD_PERF_EN
    check("StallCount", StallCount, 32'(m_sc));
    check("FlushCount", FlushCount, 32'(m_fc));
`endif
    if (!reset) begin
      if (e_sd && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (e_fe && m_fc < 64'hFFFF_FFFF) m_fc++;
      if (go) begin
        m_busy = 1; m_elapsed = 0;
      end else if (m_busy) begin
        if (rel) begin
          m_busy = 0;
          if (tmo_hit) m_err = 1;
        end else begin
          m_elapsed++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rreg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    step();
    reset = 0;
    step();

    // Forwarding: M beats W, PC never forwards
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3;
    Ra1E = 3; Ra2E = 4;
    step();
    Ra1E = 15; WA3M = 15;
    step();
    idle_inputs();

    // Load-use stall then release
    MemtoRegE = 1; WA3E = 5; Ra2D = 5;
    step();
    MemtoRegE = 0;
    step();

    // Multicycle op, MulDone four cycles after MulGo
    MulStartE = 1;
    step();
    MulStartE = 0;
    repeat (3) step();
    MulDone = 1;
    step();
    MulDone = 0;
    step();

    // Branch squashes a start
    MulStartE = 1; BranchTakenE = 1;
    step();
    MulStartE = 0; BranchTakenE = 0;
    step();

    // Timeout release then sticky error
    MulStartE = 1;
    step();
    MulStartE = 0;
    repeat (TMO + 2) step();
    MulDone = 1;
    step();
    MulDone = 0;
    reset = 1;
    step();
    reset = 0;
    step();

    // Reset in the middle of a busy period
    MulStartE = 1;
    step();
    MulStartE = 0;
    repeat (2) step();
    reset = 1;
    step();
    reset = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      Ra1D = rreg(); Ra2D = rreg();
      Ra1E = rreg(); Ra2E = rreg();
      WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
      RegWriteM = $urandom_range(0, 1) == 1;
      RegWriteW = $urandom_range(0, 1) == 1;
      MemtoRegE = $urandom_range(0, 3) == 0;
      PCSrcD = $urandom_range(0, 7) == 0;
      PCSrcE = $urandom_range(0, 7) == 0;
      PCSrcM = $urandom_range(0, 7) == 0;
      PCSrcW = $urandom_range(0, 7) == 0;
      BranchTakenE = $urandom_range(0, 5) == 0;
      MulStartE = $urandom_range(0, 3) == 0;
      MulDone = $urandom_range(0, 6) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
